// File: rtl/mod_counter_pkg.sv
// Shared definitions for the modulo-N up/down counter: direction encodings
// and the load clamp helper.
package mod_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Compared one bit wider than the counter so a modulus of 2**WIDTH never clamps.
  function automatic logic [32:0] clamp_load(input logic [32:0] d, input logic [32:0] modulus);
    logic [32:0] r;
    if (d < modulus) begin
      r = d;
    end else begin
      r = modulus - 33'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_counter_cmp.sv
// Registered equality comparator; match lines up with the counter value it
// was computed from. Only instantiated when MOD_COUNTER_CMP_EN is defined.
module mod_counter_cmp
  import mod_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q_next,
  input  logic [WIDTH-1:0] cmp,
  output logic             match
);

  logic match_r;
  logic match_next_s;

  // Equality against the value q takes at the coming edge.
  always_comb begin
    match_next_s = 1'b0;
    if (q_next == cmp) begin
      match_next_s = 1'b1;
    end else begin
      match_next_s = 1'b0;
    end
  end

  // Match register, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      match_r <= 1'b0;
    end else begin
      match_r <= match_next_s;
    end
  end

  assign match = match_r;

endmodule

// File: rtl/mod_counter.sv
// Parametrised modulo-N up/down counter with load clamp, combinational
// terminal count and registered wrap pulse. MOD_COUNTER_CMP_EN adds cmp/match.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int              WIDTH   = 8,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  input  logic             en,
  input  logic             up,
`ifdef MOD_COUNTER_CMP_EN
  input  logic [WIDTH-1:0] cmp,
  output logic             match,
`endif
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [32:0]      MOD_EXT = 33'(MODULUS);
  localparam logic [WIDTH-1:0] TERM    = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] ZERO    = WIDTH'(64'd0);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(64'd1);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next_s;
  logic [WIDTH-1:0] load_val_s;
  logic             wrap_r;
  logic             wrap_next_s;
  logic             at_end_s;

  assign load_val_s = WIDTH'(clamp_load(33'(d), MOD_EXT));

  // Boundary in the current direction: top of range going up, zero going down.
  always_comb begin
    at_end_s = 1'b0;
    case (up)
      DIR_UP:   at_end_s = (q_r == TERM);
      DIR_DOWN: at_end_s = (q_r == ZERO);
      default:  at_end_s = 1'b0;
    endcase
  end

  assign tc = en & ~load & at_end_s;

  // Next count: load beats enable; wrap is explicit so odd moduli stay exact.
  always_comb begin
    q_next_s    = q_r;
    wrap_next_s = 1'b0;
    if (load) begin
      q_next_s    = load_val_s;
      wrap_next_s = 1'b0;
    end else if (en) begin
      wrap_next_s = at_end_s;
      case (up)
        DIR_UP: begin
          if (at_end_s) begin
            q_next_s = ZERO;
          end else begin
            q_next_s = q_r + ONE;
          end
        end
        DIR_DOWN: begin
          if (at_end_s) begin
            q_next_s = TERM;
          end else begin
            q_next_s = q_r - ONE;
          end
        end
        default: begin
          q_next_s    = q_r;
          wrap_next_s = 1'b0;
        end
      endcase
    end else begin
      q_next_s    = q_r;
      wrap_next_s = 1'b0;
    end
  end

  // Count and wrap registers; reset overrides load and enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r    <= ZERO;
      wrap_r <= 1'b0;
    end else begin
      q_r    <= q_next_s;
      wrap_r <= wrap_next_s;
    end
  end

  assign q    = q_r;
  assign wrap = wrap_r;

`ifdef MOD_COUNTER_CMP_EN
  mod_counter_cmp #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .clk    (clk),
    .reset  (reset),
    .q_next (q_next_s),
    .cmp    (cmp),
    .match  (match)
  );
`endif

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: directed steps plus random traffic
// against an arithmetic reference model, and a two-stage decade cascade.
module tb_mod_counter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, load, en, up, cen;
  logic [3:0] d;
  logic [3:0] qa;  logic tca, wrapa;
  logic [2:0] qb;  logic tcb, wrapb;
  logic [0:0] qc;  logic tcc, wrapc;
  logic [3:0] qlo, qhi;
  logic       tclo, tchi, wraplo, wraphi;
`ifdef MOD_COUNTER_CMP_EN
  logic [3:0] cmp;
  logic       matcha, mb, mc, mlo, mhi;
  int         mmatch;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int mq[3];
  int mw[3];
  int mods[3] = '{10, 8, 2};

  mod_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
    .clk(clk), .reset(reset), .d(d), .load(load), .en(en), .up(up),
`ifdef MOD_COUNTER_CMP_EN
    .cmp(cmp), .match(matcha),
`endif
    .q(qa), .tc(tca), .wrap(wrapa));

  mod_counter #(.WIDTH(3)) dut_b (
    .clk(clk), .reset(reset), .d(d[2:0]), .load(load), .en(en), .up(up),
`ifdef MOD_COUNTER_CMP_EN
    .cmp(3'd0), .match(mb),
`endif
    .q(qb), .tc(tcb), .wrap(wrapb));

  mod_counter #(.WIDTH(1)) dut_c (
    .clk(clk), .reset(reset), .d(d[0:0]), .load(load), .en(en), .up(up),
`ifdef MOD_COUNTER_CMP_EN
    .cmp(1'b0), .match(mc),
`endif
    .q(qc), .tc(tcc), .wrap(wrapc));

  mod_counter #(.WIDTH(4), .MODULUS(10)) dut_lo (
    .clk(clk), .reset(reset), .d(4'd0), .load(1'b0), .en(cen), .up(1'b1),
`ifdef MOD_COUNTER_CMP_EN
    .cmp(4'd0), .match(mlo),
`endif
    .q(qlo), .tc(tclo), .wrap(wraplo));

  mod_counter #(.WIDTH(4), .MODULUS(10)) dut_hi (
    .clk(clk), .reset(reset), .d(4'd0), .load(1'b0), .en(tclo), .up(1'b1),
`ifdef MOD_COUNTER_CMP_EN
    .cmp(4'd0), .match(mhi),
`endif
    .q(qhi), .tc(tchi), .wrap(wraphi));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check tc before the edge, then q/wrap after it.
  task automatic step(input logic r, input logic ld, input logic e, input logic u,
                      input logic [3:0] dv);
    logic [31:0] qo[3];
    logic [31:0] wo[3];
    logic [31:0] to[3];
    int dk, m, tce;
    reset = r; load = ld; en = e; up = u; d = dv;
    #1;
    to = '{32'(tca), 32'(tcb), 32'(tcc)};
    for (int k = 0; k < 3; k++) begin
      m   = mods[k];
      tce = (e && !ld && (u ? (mq[k] == m - 1) : (mq[k] == 0))) ? 1 : 0;
      check($sformatf("tc[%0d]", k), to[k], 32'(tce));
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      m  = mods[k];
      dk = int'(dv) % (k == 0 ? 16 : (k == 1 ? 8 : 2));
      if (r) begin
        mq[k] = 0; mw[k] = 0;
      end else if (ld) begin
        mq[k] = (dk < m) ? dk : m - 1; mw[k] = 0;
      end else if (e) begin
        mw[k] = (u ? (mq[k] == m - 1) : (mq[k] == 0)) ? 1 : 0;
        mq[k] = u ? (mq[k] + 1) % m : (mq[k] + m - 1) % m;
      end else begin
        mw[k] = 0;
      end
    end
`ifdef MOD_COUNTER_CMP_EN
    mmatch = r ? 0 : ((mq[0] == int'(cmp)) ? 1 : 0);
`endif
    #1;
    qo = '{32'(qa), 32'(qb), 32'(qc)};
    wo = '{32'(wrapa), 32'(wrapb), 32'(wrapc)};
    for (int k = 0; k < 3; k++) begin
      check($sformatf("q[%0d]", k), qo[k], 32'(mq[k]));
      check($sformatf("wrap[%0d]", k), wo[k], 32'(mw[k]));
    end
`ifdef MOD_COUNTER_CMP_EN
    check("match", 32'(matcha), 32'(mmatch));
`endif
    @(negedge clk);
  endtask

  int exp_up[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int exp_dn[5]  = '{2, 1, 0, 9, 8};

  initial begin
    cen = 1'b0;
    for (int k = 0; k < 3; k++) begin mq[k] = 0; mw[k] = 0; end
`ifdef MOD_COUNTER_CMP_EN
    cmp = 4'd15; mmatch = 0;
`endif
    // reset with load and en high
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    check("reset_q", 32'(qa), 32'd0);
    check("reset_wrap", 32'(wrapa), 32'd0);

    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
      check("up_seq", 32'(qa), 32'(exp_up[i]));
      check("up_wrap", 32'(wrapa), (exp_up[i] == 0) ? 32'd1 : 32'd0);
    end

    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
    check("load3", 32'(qa), 32'd3);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      check("dn_seq", 32'(qa), 32'(exp_dn[i]));
      check("dn_wrap", 32'(wrapa), (exp_dn[i] == 9) ? 32'd1 : 32'd0);
    end

    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd12);
    check("clamp12", 32'(qa), 32'd9);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd7);
    check("load_wins", 32'(qa), 32'd7);

    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd5);
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'd2);
    check("mid_reset", 32'(qa), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    check("resume", 32'(qa), 32'd1);

    for (int i = 0; i < 300; i++) begin
`ifdef MOD_COUNTER_CMP_EN
      cmp = 4'($urandom_range(0, 9));
`endif
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)));
    end

`ifdef MOD_COUNTER_CMP_EN
    cmp = 4'd6;
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
      check("match6", 32'(matcha), (i == 6) ? 32'd1 : 32'd0);
    end
    cmp = 4'd0;
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd2);
    cmp = 4'd2;
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    check("match_hold", 32'(matcha), 32'd1);
`endif

    // decade cascade from 0:0 through 9:9 and back to 0:0
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    check("casc_rst", {24'd0, qhi, qlo}, 32'd0);
    cen = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      check("casc_lo", 32'(qlo), 32'(k % 10));
      check("casc_hi", 32'(qhi), 32'((k / 10) % 10));
      check("casc_wlo", 32'(wraplo), (k % 10 == 0) ? 32'd1 : 32'd0);
      check("casc_whi", 32'(wraphi), (k % 100 == 0) ? 32'd1 : 32'd0);
    end
    cen = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
